// File: rtl/sram_rom_loader.sv
// Packs the APF byte-wide ROM download into 16-bit little-endian words, drives timed
// write cycles into the SRAM wrapper, then hands the SRAM bus to the game read port.
module sram_rom_loader #(
  parameter int unsigned ADDR_W       = 17,
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned WE_CYCLES    = 2
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [ADDR_W:0]   ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       rd_data,
  output logic              sram_wr_en,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_din,
  input  logic [15:0]       sram_dout,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StSetup = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;
  localparam logic [1:0] StHold  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       din_q, din_d;
  logic [15:0]       rd_data_q;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              seen_q, dl_q;

  // Pack register: either an even half word, or (pk_full) a complete word deferred
  // by one cycle because another word committed in the same cycle.
  logic              pk_valid_q, pk_valid_d;
  logic              pk_full_q, pk_full_d;
  logic [ADDR_W-1:0] pk_addr_q, pk_addr_d;
  logic [7:0]        pk_lo_q, pk_lo_d;
  logic [7:0]        pk_hi_q, pk_hi_d;

  logic              slot_full_q;
  logic [ADDR_W-1:0] slot_addr_q;
  logic [15:0]       slot_data_q;

  logic              strobe, dl_rise, take, commit, accept, drop, rd_mode;
  logic [ADDR_W-1:0] byte_waddr, c_addr;
  logic [15:0]       c_data;

  assign strobe     = ioctl_wr && ioctl_download;
  assign dl_rise    = ioctl_download && !dl_q;
  assign byte_waddr = ioctl_addr[ADDR_W:1];
  assign take       = slot_full_q && (state_q == StIdle || state_q == StHold);
  assign accept     = commit && (!slot_full_q || take);
  assign drop       = commit && slot_full_q && !take;

  always_comb begin
    commit     = 1'b0;
    c_addr     = pk_addr_q;
    c_data     = {pk_hi_q, pk_lo_q};
    pk_valid_d = pk_valid_q;
    pk_full_d  = pk_full_q;
    pk_addr_d  = pk_addr_q;
    pk_lo_d    = pk_lo_q;
    pk_hi_d    = pk_hi_q;
    if (pk_valid_q && pk_full_q) begin
      commit     = 1'b1;
      pk_valid_d = 1'b0;
      pk_full_d  = 1'b0;
    end else if (pk_valid_q && (!ioctl_download || (strobe && byte_waddr != pk_addr_q))) begin
      commit     = 1'b1;
      c_data     = {8'h00, pk_lo_q};
      pk_valid_d = 1'b0;
    end
    if (strobe) begin
      if (!ioctl_addr[0]) begin
        pk_valid_d = 1'b1;
        pk_full_d  = 1'b0;
        pk_addr_d  = byte_waddr;
        pk_lo_d    = ioctl_dout;
      end else if (pk_valid_q && !pk_full_q && pk_addr_q == byte_waddr) begin
        commit     = 1'b1;
        c_addr     = byte_waddr;
        c_data     = {ioctl_dout, pk_lo_q};
        pk_valid_d = 1'b0;
      end else if (commit) begin
        pk_valid_d = 1'b1;
        pk_full_d  = 1'b1;
        pk_addr_d  = byte_waddr;
        pk_lo_d    = 8'h00;
        pk_hi_d    = ioctl_dout;
      end else begin
        commit = 1'b1;
        c_addr = byte_waddr;
        c_data = {ioctl_dout, 8'h00};
      end
    end
  end

  // HOLD may chain straight into the next SETUP, giving a SETUP+WE+1 word period.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en_d = wr_en_q;
    addr_d  = addr_q;
    din_d   = din_q;
    case (state_q)
      StIdle, StHold: begin
        if (take) begin
          state_d = StSetup;
          cnt_d   = 8'd0;
          addr_d  = slot_addr_q;
          din_d   = slot_data_q;
        end else begin
          state_d = StIdle;
        end
      end
      StSetup: begin
        if (cnt_q == 8'(SETUP_CYCLES - 1)) begin
          state_d = StWrite;
          cnt_d   = 8'd0;
          wr_en_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StWrite: begin
        if (cnt_q == 8'(WE_CYCLES - 1)) begin
          state_d = StHold;
          cnt_d   = 8'd0;
          wr_en_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    done_d = done_q;
    if (dl_rise) begin
      done_d = 1'b0;
    end else if (seen_q && !ioctl_download && !pk_valid_q && !slot_full_q && state_q == StIdle) begin
      done_d = 1'b1;
    end
    ovf_d = drop ? 1'b1 : (dl_rise ? 1'b0 : ovf_q);
  end

  assign rd_mode = (state_q == StIdle) && !ioctl_download && !pk_valid_q && !slot_full_q &&
                   !reset;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      wr_en_q     <= 1'b0;
      addr_q      <= '0;
      din_q       <= 16'h0000;
      rd_data_q   <= 16'h0000;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      seen_q      <= 1'b0;
      dl_q        <= 1'b0;
      pk_valid_q  <= 1'b0;
      pk_full_q   <= 1'b0;
      pk_addr_q   <= '0;
      pk_lo_q     <= 8'h00;
      pk_hi_q     <= 8'h00;
      slot_full_q <= 1'b0;
      slot_addr_q <= '0;
      slot_data_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      seen_q     <= seen_q || dl_rise;
      dl_q       <= ioctl_download;
      pk_valid_q <= pk_valid_d;
      pk_full_q  <= pk_full_d;
      pk_addr_q  <= pk_addr_d;
      pk_lo_q    <= pk_lo_d;
      pk_hi_q    <= pk_hi_d;
      if (rd_mode) begin
        rd_data_q <= sram_dout;
      end
      if (accept) begin
        slot_full_q <= 1'b1;
        slot_addr_q <= c_addr;
        slot_data_q <= c_data;
      end else if (take) begin
        slot_full_q <= 1'b0;
      end
    end
  end

  assign sram_wr_en = wr_en_q;
  assign sram_addr  = rd_mode ? rd_addr : addr_q;
  assign sram_din   = din_q;
  assign rd_data    = rd_data_q;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign busy       = (state_q != StIdle) || pk_valid_q || slot_full_q;

endmodule

// File: tb/tb_sram_rom_loader.sv
// Bench for sram_rom_loader: directed downloads against a word-list model of the
// packing rules, with a per-cycle monitor of the SRAM write protocol.
module tb_sram_rom_loader;
  localparam int unsigned ADDR_W    = 17;
  localparam int unsigned WE_CYCLES = 2;

  logic              clk_sys = 1'b0;
  logic              reset = 1'b1;
  logic              ioctl_download = 1'b0;
  logic              ioctl_wr = 1'b0;
  logic [ADDR_W:0]   ioctl_addr = '0;
  logic [7:0]        ioctl_dout = 8'h00;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [15:0]       rd_data, sram_din, sram_dout;
  logic              sram_wr_en, busy, done, overflow;
  logic [ADDR_W-1:0] sram_addr;

  logic [15:0] mem [0:(1<<ADDR_W)-1];

  sram_rom_loader #(.ADDR_W(ADDR_W), .SETUP_CYCLES(1), .WE_CYCLES(WE_CYCLES)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .rd_addr(rd_addr), .rd_data(rd_data),
    .sram_wr_en(sram_wr_en), .sram_addr(sram_addr), .sram_din(sram_din),
    .sram_dout(sram_dout), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;

  // Wrapper model: asynchronous read, write on the clock while wr_en is high.
  assign sram_dout = mem[sram_addr];
  always @(posedge clk_sys) if (sram_wr_en) mem[sram_addr] <= sram_din;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [15:0]       d;
  } wr_t;

  wr_t               exp_q[$];
  bit                half_v = 1'b0;
  logic [ADDR_W-1:0] half_a;
  logic [7:0]        half_lo;
  bit                allow_drop = 1'b0;
  bit                ovf_zero = 1'b1;
  int                writes_seen = 0;
  int                total = 0;
  int                bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_q.push_back(w);
  endtask

  // Word-level packing rules: flush on address change, commit on odd byte.
  task automatic model_byte(input logic [ADDR_W:0] addr, input logic [7:0] b);
    logic [ADDR_W-1:0] wa;
    wa = addr[ADDR_W:1];
    if (half_v && wa != half_a) begin
      push_exp(half_a, {8'h00, half_lo});
      half_v = 1'b0;
    end
    if (!addr[0]) begin
      half_v  = 1'b1;
      half_a  = wa;
      half_lo = b;
    end else if (half_v) begin
      push_exp(wa, {b, half_lo});
      half_v = 1'b0;
    end else begin
      push_exp(wa, {b, 8'h00});
    end
  endtask

  always @(negedge clk_sys) begin : mon
    logic              prev_we;
    logic [ADDR_W-1:0] prev_a;
    logic [15:0]       prev_d;
    int                run;
    wr_t               w;
    if (reset) begin
      prev_we = 1'b0;
      run     = 0;
    end else begin
      if (sram_wr_en && !prev_we) begin
        chk("setup_addr", 32'(sram_addr), 32'(prev_a));
        chk("setup_din", 32'(sram_din), 32'(prev_d));
        writes_seen++;
        if (allow_drop) begin
          while (exp_q.size() > 0 && (exp_q[0].a != sram_addr || exp_q[0].d != sram_din))
            void'(exp_q.pop_front());
        end
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL wr_unexpected: got addr %0h din %0h want no write", sram_addr, sram_din);
        end else begin
          w = exp_q.pop_front();
          if (w.a !== sram_addr || w.d !== sram_din) begin
            bad++;
            $display("FAIL wr_word: got %0h:%0h want %0h:%0h", sram_addr, sram_din, w.a, w.d);
          end
        end
        run = 1;
      end else if (sram_wr_en) begin
        chk("we_addr_stable", 32'(sram_addr), 32'(prev_a));
        chk("we_din_stable", 32'(sram_din), 32'(prev_d));
        run++;
      end else if (prev_we) begin
        chk("we_len", run, WE_CYCLES);
        chk("hold_addr", 32'(sram_addr), 32'(prev_a));
        chk("hold_din", 32'(sram_din), 32'(prev_d));
      end
      if (done) begin
        chk("done_pending", exp_q.size(), 0);
        chk("done_busy", 32'(busy), 0);
      end
      if (ovf_zero) chk("overflow_low", 32'(overflow), 0);
      prev_we = sram_wr_en;
      prev_a  = sram_addr;
      prev_d  = sram_din;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic send(input logic [ADDR_W:0] a, input logic [7:0] d);
    @(posedge clk_sys); #1;
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    model_byte(a, d);
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl();
    @(posedge clk_sys); #1;
    ioctl_download = 1'b1;
    half_v = 1'b0;
  endtask

  task automatic end_dl();
    @(posedge clk_sys); #1;
    ioctl_download = 1'b0;
    if (half_v) push_exp(half_a, {8'h00, half_lo});
    half_v = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk_sys); #1;
      n++;
    end
    chk(name, 32'(done), 1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ws0;
    int n;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'h0000;
    #3;
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_wr_en", 32'(sram_wr_en), 0);
    chk("rst_addr", 32'(sram_addr), 0);
    chk("rst_din", 32'(sram_din), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_overflow", 32'(overflow), 0);
    @(posedge clk_sys); #1;
    reset = 1'b0;
    idle(2);

    // Test 1: four bytes, one strobe every 6 cycles
    start_dl();
    send(18'd0, 8'h11); idle(4);
    send(18'd1, 8'h22); idle(4);
    send(18'd2, 8'h33); idle(4);
    send(18'd3, 8'h44); idle(4);
    end_dl();
    wait_done("t1_done");
    chk("t1_word0", 32'(mem[0]), 32'h2211);
    chk("t1_word1", 32'(mem[1]), 32'h4433);

    // Test 5: game read port, one-cycle latency
    @(posedge clk_sys); #1;
    rd_addr = 17'd1;
    @(posedge clk_sys); #1;
    chk("rd_word1", 32'(rd_data), 32'h4433);
    rd_addr = 17'd0;
    @(posedge clk_sys); #1;
    chk("rd_word0", 32'(rd_data), 32'h2211);

    // Test 2: trailing half word flushed on download fall
    start_dl();
    send(18'd0, 8'hAA);
    send(18'd1, 8'hBB);
    send(18'd2, 8'hCC);
    idle(1);
    end_dl();
    wait_done("t2_done");
    chk("t2_word0", 32'(mem[0]), 32'hBBAA);
    chk("t2_word1", 32'(mem[1]), 32'h00CC);

    // Test 3: non-contiguous addresses
    start_dl();
    send(18'd4, 8'h5A); idle(3);
    send(18'd11, 8'h77);
    end_dl();
    wait_done("t3_done");
    chk("t3_word2", 32'(mem[2]), 32'h005A);
    chk("t3_word5", 32'(mem[5]), 32'h7700);

    // Test 4: back-to-back strobes overrun the single pending slot
    ovf_zero   = 1'b0;
    allow_drop = 1'b1;
    ws0        = writes_seen;
    start_dl();
    @(posedge clk_sys); #1;
    chk("t4_done_clr", 32'(done), 0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_sys); #1;
      ioctl_wr   = 1'b1;
      ioctl_addr = i[ADDR_W:0];
      ioctl_dout = 8'h80 + 8'(i);
      model_byte(i[ADDR_W:0], 8'h80 + 8'(i));
      if (i >= 1) chk("t4_busy", 32'(busy), 1);
    end
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    end_dl();
    wait_done("t4_done");
    chk("t4_overflow", 32'(overflow), 1);
    chk("t4_missing", 32'((writes_seen - ws0) < 4), 1);
    allow_drop = 1'b0;

    // Test 6: next download clears overflow; reset in mid-write
    start_dl();
    @(posedge clk_sys); #1;
    chk("t6_ovf_clr", 32'(overflow), 0);
    chk("t6_done_clr", 32'(done), 0);
    ovf_zero = 1'b1;
    send(18'd0, 8'h01);
    send(18'd1, 8'h02);
    n = 0;
    while (!sram_wr_en && n < 50) begin
      @(posedge clk_sys); #1;
      n++;
    end
    chk("t6_we_seen", 32'(sram_wr_en), 1);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_wr_en", 32'(sram_wr_en), 0);
    chk("t6_addr", 32'(sram_addr), 0);
    chk("t6_din", 32'(sram_din), 0);
    chk("t6_rd_data", 32'(rd_data), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_done", 32'(done), 0);
    chk("t6_overflow", 32'(overflow), 0);
    exp_q.delete();
    half_v = 1'b0;
    ioctl_download = 1'b0;
    @(posedge clk_sys); #1;
    reset = 1'b0;
    ws0 = writes_seen;
    idle(15);
    chk("t6_no_write", writes_seen - ws0, 0);
    chk("t6_done_after", 32'(done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_rom_loader.md
Name: sram_rom_loader

Overview:
- Upstream feeder for the SRAM storage wrapper: consumes the bridge's byte-wide ROM download stream and packs bytes into 16-bit little-endian words.
- Drives timed write cycles into the wrapper: address/data setup, write-enable pulse, hold.
- After download, hands the SRAM bus to the game's read port and returns registered read data.
- Sits between the APF data loader and the SRAM wrapper.

Parameters:
- ADDR_W, 17, word address width; the byte address is ADDR_W+1 bits.
- SETUP_CYCLES, 1, cycles that addr/din are stable before wr_en rises (≥1).
- WE_CYCLES, 2, cycles wr_en is held high (≥1).

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ioctl_download  in  1  high while a ROM download is in progress
- ioctl_wr  in  1  one-cycle byte strobe
- ioctl_addr  in  ADDR_W+1  byte address
- ioctl_dout  in  8  byte data
- rd_addr  in  ADDR_W  game word read address
- rd_data  out  16  registered read data
- sram_wr_en  out  1  to wrapper wr_en
- sram_addr  out  ADDR_W  to wrapper addr
- sram_din  out  16  to wrapper din
- sram_dout  in  16  from wrapper dout
- busy  out  1  write FSM not IDLE, or a word/byte is pending
- done  out  1  download complete and all writes retired
- overflow  out  1  sticky: a byte was dropped

Behaviour:
- Reset (async, immediate):
  - FSM=IDLE; sram_wr_en=0; sram_addr=0; sram_din=0; rd_data=0.
  - done=0; overflow=0; pack register and pending-word slot empty.
- Packing (ioctl_wr=1):
  - Word address = ioctl_addr[ADDR_W:1].
  - Even byte goes to bits [7:0]; odd byte goes to bits [15:8].
  - Word commits to the pending slot when:
    - the odd byte arrives;
    - a byte arrives for a different word address while a half word is packed (old word flushes with its missing half = 0x00);
    - ioctl_download falls with a half word packed (flush, missing half = 0x00).
  - An odd byte with no packed even byte for the same word commits as {byte, 0x00}.
- Pending slot: one entry.
  - If a commit occurs while the slot is full: that word is dropped and overflow is set.
  - overflow clears only on reset or a rising edge of ioctl_download.
- Write FSM:
  - IDLE → SETUP when the slot is full: latch sram_addr/sram_din, free the slot.
  - SETUP: SETUP_CYCLES cycles with wr_en=0 → WRITE.
  - WRITE: WE_CYCLES cycles with wr_en=1 → HOLD.
  - HOLD: 1 cycle, wr_en=0, addr/din held → IDLE.
  - sram_addr and sram_din never change while wr_en=1.
  - Minimum word period = SETUP_CYCLES+WE_CYCLES+1 cycles (4 at defaults).
- Read path:
  - In IDLE with ioctl_download=0 and nothing pending, sram_addr follows rd_addr combinationally.
  - rd_data <= sram_dout every such cycle, giving 1-cycle latency from rd_addr.
  - Otherwise rd_data holds its last value.
- done:
  - Clears on the rising edge of ioctl_download.
  - Sets the first cycle that ioctl_download=0, the pack register is empty, the slot is empty and the FSM is IDLE, after at least one download.
- Byte strobes while ioctl_download=0 are ignored.
- A rising edge of ioctl_download mid-write does not abort the write in flight.
- Reset asserted mid-WRITE drops sram_wr_en the same instant (async).

Test Plan:
1. Download bytes 0x11,0x22,0x33,0x44 at addrs 0..3, one strobe per 6 cycles -> writes word0=0x2211, word1=0x4433, each with wr_en high exactly 2 cycles, addr/din stable from 1 cycle before to 1 cycle after; done=1 after the last HOLD.
2. Bytes 0xAA,0xBB,0xCC at addrs 0..2, then download falls -> word0=0xBBAA, word1=0x00CC flushed; done rises only after word1's HOLD.
3. Non-contiguous: 0x5A at addr 4, then 0x77 at addr 11 -> word2=0x005A, word5=0x7700.
4. Strobes on every cycle for 8 consecutive bytes -> overflow=1, busy stays high, at least one word missing; next download rising edge clears overflow and done.
5. After test 1 completes, rd_addr=1 -> rd_data=0x4433 on the next clock; rd_addr=0 -> 0x2211 the cycle after.
6. Assert reset during WRITE -> sram_wr_en=0 before the next clock edge, all outputs at reset values, no further write issued after reset release.
